// File: rtl/mcp_lcseq.sv
// rtl/mcp_lcseq.sv - MicROM microsequencer: location counter, branch decode, return stack, trap/stall.
// Optional breakpoint logic is enabled by defining LSI11_SEQ_BPT_EN.
module mcp_lcseq #(
    parameter logic [10:0] RESET_VECTOR = 11'h000,
    parameter logic [10:0] TRAP_VECTOR  = 11'h001,
    parameter int          RS_DEPTH     = 4
) (
    input  logic        pin_clk,
    input  logic        pin_rst_n,
    output logic [10:0] pin_lc,
    input  logic [21:0] pin_mo,
    input  logic [7:0]  pin_cond,
    input  logic        pin_stall,
    input  logic        pin_trap,
    output logic [17:0] pin_mi,
    output logic [3:0]  pin_ttl,
    output logic        pin_mv,
    output logic [10:0] pin_lcr,
    output logic        pin_err,
    input  logic [10:0] pin_bpt_addr,
    output logic        pin_bpt
);

    localparam int CW = $clog2(RS_DEPTH + 1);

    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] lcr_q, lcr_d;
    logic [10:0] stk_q [RS_DEPTH];
    logic [10:0] stk_d [RS_DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        mask_q, mask_d;

    logic [1:0]  op;
    logic [2:0]  csel;
    logic        rflag;
    logic [10:0] tgt;
    logic [10:0] lcr_inc;
    logic        stk_empty;
    logic        stk_full;

    logic [10:0] op_addr;
    logic        op_push;
    logic        op_pop;
    logic        op_uflow;

    logic        bpt_hold;
    logic        bpt_hit;

    assign op        = pin_mo[17:16];
    assign csel      = pin_mo[15:13];
    assign rflag     = pin_mo[12];
    assign tgt       = pin_mo[10:0];
    assign lcr_inc   = lcr_q + 11'd1;
    assign stk_empty = (cnt_q == '0);
    assign stk_full  = (cnt_q == CW'(RS_DEPTH));

    assign pin_mi    = pin_mo[17:0];
    assign pin_ttl   = pin_mo[21:18];
    assign pin_lcr   = lcr_q;
    assign pin_err   = err_q;

    // Address the sequencing field asks for, before stall/trap override.
    always_comb begin
        op_addr  = lcr_inc;
        op_push  = 1'b0;
        op_pop   = 1'b0;
        op_uflow = 1'b0;
        case (op)
            2'b00: op_addr = lcr_inc;
            2'b01: op_addr = tgt;
            2'b10: op_addr = pin_cond[csel] ? tgt : lcr_inc;
            default: begin
                if (!rflag) begin
                    op_push = 1'b1;
                    op_addr = tgt;
                end else if (stk_empty) begin
                    op_uflow = 1'b1;
                    op_addr  = RESET_VECTOR;
                end else begin
                    op_pop  = 1'b1;
                    op_addr = stk_q[0];
                end
            end
        endcase
    end

    always_comb begin
        logic        do_push;
        logic        do_pop;
        logic [10:0] push_val;

        state_d  = state_q;
        lcr_d    = lcr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        mask_d   = mask_q;
        stk_d    = stk_q;
        pin_lc   = RESET_VECTOR;
        pin_mv   = 1'b0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        push_val = lcr_inc;

        case (state_q)
            S_BOOT: begin
                pin_lc  = RESET_VECTOR;
                lcr_d   = RESET_VECTOR;
                state_d = S_RUN;
            end
            default: begin
                if (pin_stall || bpt_hold) begin
                    pin_lc = lcr_q;
                end else if (pin_trap && !mask_q) begin
                    // Trap preserves where the interrupted word would have gone.
                    pin_mv   = 1'b1;
                    pin_lc   = TRAP_VECTOR;
                    do_push  = 1'b1;
                    push_val = op_addr;
                    mask_d   = 1'b1;
                end else begin
                    pin_mv  = 1'b1;
                    pin_lc  = op_addr;
                    do_push = op_push;
                    do_pop  = op_pop;
                    mask_d  = 1'b0;
                    if (op_uflow) begin
                        err_d = 1'b1;
                    end
                end
                lcr_d = pin_lc;
            end
        endcase

        // Index 0 is the top; a push onto a full stack falls off the bottom.
        if (do_push) begin
            for (int i = RS_DEPTH - 1; i > 0; i--) begin
                stk_d[i] = stk_q[i-1];
            end
            stk_d[0] = push_val;
            if (stk_full) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (do_pop) begin
            for (int i = 0; i < RS_DEPTH - 1; i++) begin
                stk_d[i] = stk_q[i+1];
            end
            stk_d[RS_DEPTH-1] = 11'd0;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state_q <= S_BOOT;
            lcr_q   <= RESET_VECTOR;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mask_q  <= 1'b0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                stk_q[i] <= 11'd0;
            end
        end else begin
            state_q <= state_d;
            lcr_q   <= lcr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                stk_q[i] <= stk_d[i];
            end
        end
    end

`ifdef LSI11_SEQ_BPT_EN
    logic        bpt_hold_q, bpt_hold_d;
    logic [10:0] bpt_addr_q, bpt_addr_d;

    // Hold releases in the same cycle the breakpoint address is changed.
    assign bpt_hold = bpt_hold_q && (pin_bpt_addr == bpt_addr_q);
    assign bpt_hit  = (state_q == S_RUN) && !pin_stall && !bpt_hold &&
                      (lcr_q == pin_bpt_addr);
    assign pin_bpt  = bpt_hit;

    always_comb begin
        bpt_hold_d = bpt_hit || bpt_hold;
        bpt_addr_d = bpt_hit ? pin_bpt_addr : bpt_addr_q;
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            bpt_hold_q <= 1'b0;
            bpt_addr_q <= 11'd0;
        end else begin
            bpt_hold_q <= bpt_hold_d;
            bpt_addr_q <= bpt_addr_d;
        end
    end
`else
    logic unused_bpt;

    assign bpt_hold   = 1'b0;
    assign bpt_hit    = 1'b0;
    assign pin_bpt    = bpt_hit;
    assign unused_bpt = ^pin_bpt_addr;
`endif

endmodule

// File: tb/tb_mcp_lcseq.sv
// tb/tb_mcp_lcseq.sv - directed self-checking bench for mcp_lcseq with a registered MicROM model.
module tb_mcp_lcseq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] lc;
    logic [21:0] mo;
    logic [7:0]  cond;
    logic        stall;
    logic        trap;
    logic [17:0] mi;
    logic [3:0]  ttl;
    logic        mv;
    logic [10:0] lcr;
    logic        err;
    logic [10:0] bpt_addr;
    logic        bpt;

    logic [21:0] rom [2048];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mo <= rom[lc];

    mcp_lcseq dut (
        .pin_clk      (clk),
        .pin_rst_n    (rst_n),
        .pin_lc       (lc),
        .pin_mo       (mo),
        .pin_cond     (cond),
        .pin_stall    (stall),
        .pin_trap     (trap),
        .pin_mi       (mi),
        .pin_ttl      (ttl),
        .pin_mv       (mv),
        .pin_lcr      (lcr),
        .pin_err      (err),
        .pin_bpt_addr (bpt_addr),
        .pin_bpt      (bpt)
    );

    function automatic logic [21:0] mw(input logic [3:0] t, input logic [1:0] op,
                                       input logic [2:0] sel, input logic rf,
                                       input logic [10:0] tg);
        return {t, op, sel, rf, 1'b0, tg};
    endfunction

    function automatic logic [21:0] jmp(input logic [10:0] tg);
        return mw(4'h0, 2'b01, 3'd0, 1'b0, tg);
    endfunction

    function automatic logic [21:0] call(input logic [10:0] tg);
        return mw(4'h0, 2'b11, 3'd0, 1'b0, tg);
    endfunction

    function automatic logic [21:0] ret();
        return mw(4'h0, 2'b11, 3'd0, 1'b1, 11'h000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot();
        @(negedge clk);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_lc", 32'(lc), 32'h000);
        chk("rst_mv", 32'(mv), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_lc", 32'(lc), 32'h000);
        chk("boot_mv", 32'(mv), 32'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        cond     = 8'h00;
        stall    = 1'b0;
        trap     = 1'b0;
        bpt_addr = 11'h7FF;
        for (int i = 0; i < 2048; i++) rom[i] = 22'h0;

        // Boot, conditional branch, call/return, empty-stack return
        rom[11'h002] = jmp(11'h010);
        rom[11'h010] = mw(4'hA, 2'b10, 3'd3, 1'b0, 11'h155);
        rom[11'h155] = jmp(11'h020);
        rom[11'h020] = call(11'h300);
        rom[11'h300] = ret();
        rom[11'h021] = jmp(11'h040);
        rom[11'h040] = ret();

        assert_reset();
        chk("rst_bpt", 32'(bpt), 32'h0);
        release_reset();
        slot(); #1;
        chk("a_lc1", 32'(lc), 32'h001);
        chk("a_mv1", 32'(mv), 32'h1);
        chk("a_lcr0", 32'(lcr), 32'h000);
        slot(); #1;
        chk("a_lc2", 32'(lc), 32'h002);
        slot(); #1;
        chk("a_lcr2", 32'(lcr), 32'h002);
        chk("a_jmp", 32'(lc), 32'h010);
        slot(); cond = 8'h08; #1;
        chk("a_cond_taken", 32'(lc), 32'h155);
        chk("a_mi", 32'(mi), 32'h26155);
        chk("a_ttl", 32'(ttl), 32'hA);
        cond = 8'hF7; #1;
        chk("a_cond_not", 32'(lc), 32'h011);
        cond = 8'h08; #1;
        slot(); cond = 8'h00; #1;
        chk("a_lcr155", 32'(lcr), 32'h155);
        chk("a_lc020", 32'(lc), 32'h020);
        slot(); #1;
        chk("a_call", 32'(lc), 32'h300);
        slot(); #1;
        chk("a_ret", 32'(lc), 32'h021);
        chk("a_err0", 32'(err), 32'h0);
        slot(); #1;
        chk("a_lc040", 32'(lc), 32'h040);
        slot(); #1;
        chk("a_uflow_lc", 32'(lc), 32'h000);
        slot(); #1;
        chk("a_uflow_err", 32'(err), 32'h1);
        chk("a_after_uflow", 32'(lc), 32'h001);
        slot(); #1;
        chk("a_err_sticky", 32'(err), 32'h1);
        chk("a_bpt", 32'(bpt), 32'h0);

        // Five nested calls into a four-deep stack
        rom[11'h002] = jmp(11'h100);
        rom[11'h100] = call(11'h110);
        rom[11'h110] = call(11'h120);
        rom[11'h120] = call(11'h130);
        rom[11'h130] = call(11'h140);
        rom[11'h140] = call(11'h150);
        rom[11'h150] = ret();
        rom[11'h141] = ret();
        rom[11'h131] = ret();
        rom[11'h121] = ret();
        rom[11'h111] = ret();
        assert_reset();
        release_reset();
        slot(); #1; chk("b_lc1", 32'(lc), 32'h001);
        slot(); #1; chk("b_lc2", 32'(lc), 32'h002);
        slot(); #1; chk("b_lc100", 32'(lc), 32'h100);
        slot(); #1; chk("b_call1", 32'(lc), 32'h110);
        slot(); #1; chk("b_call2", 32'(lc), 32'h120);
        slot(); #1; chk("b_call3", 32'(lc), 32'h130);
        slot(); #1; chk("b_call4", 32'(lc), 32'h140);
        slot(); #1;
        chk("b_call5", 32'(lc), 32'h150);
        chk("b_err_before", 32'(err), 32'h0);
        slot(); #1;
        chk("b_ovf_err", 32'(err), 32'h1);
        chk("b_ret1", 32'(lc), 32'h141);
        slot(); #1; chk("b_ret2", 32'(lc), 32'h131);
        slot(); #1; chk("b_ret3", 32'(lc), 32'h121);
        slot(); #1; chk("b_ret4", 32'(lc), 32'h111);
        slot(); #1;
        chk("b_lcr111", 32'(lcr), 32'h111);
        chk("b_oldest_lost", 32'(lc), 32'h000);

        // Stall with pending trap, trap masking and re-entry
        rom[11'h002] = jmp(11'h050);
        assert_reset();
        release_reset();
        slot(); #1; chk("c_lc1", 32'(lc), 32'h001);
        slot(); #1; chk("c_lc2", 32'(lc), 32'h002);
        slot(); #1;
        chk("c_lc050", 32'(lc), 32'h050);
        rom[11'h001] = ret();
        for (int i = 0; i < 3; i++) begin
            slot(); stall = 1'b1; trap = 1'b1; #1;
            chk("c_stall_lc", 32'(lc), 32'h050);
            chk("c_stall_mv", 32'(mv), 32'h0);
            chk("c_stall_lcr", 32'(lcr), 32'h050);
        end
        slot(); stall = 1'b0; #1;
        chk("c_trap_lc", 32'(lc), 32'h001);
        chk("c_trap_mv", 32'(mv), 32'h1);
        slot(); #1;
        chk("c_trap_lcr", 32'(lcr), 32'h001);
        chk("c_masked_ret", 32'(lc), 32'h051);
        slot(); #1;
        chk("c_reentry", 32'(lc), 32'h001);
        slot(); trap = 1'b0; #1;
        chk("c_ret2", 32'(lc), 32'h052);
        slot(); #1;
        chk("c_resume", 32'(lc), 32'h053);
        chk("c_err0", 32'(err), 32'h0);

        // Reset with two entries on the stack, then underflow
        rom[11'h001] = 22'h0;
        rom[11'h002] = jmp(11'h060);
        rom[11'h060] = call(11'h070);
        rom[11'h070] = call(11'h080);
        assert_reset();
        release_reset();
        slot(); #1; chk("d_lc1", 32'(lc), 32'h001);
        slot(); #1; chk("d_lc2", 32'(lc), 32'h002);
        slot(); #1; chk("d_lc060", 32'(lc), 32'h060);
        slot(); #1; chk("d_call1", 32'(lc), 32'h070);
        slot(); #1; chk("d_call2", 32'(lc), 32'h080);
        slot(); #1;
        chk("d_mv_run", 32'(mv), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("d_rst_mv", 32'(mv), 32'h0);
        chk("d_rst_lc", 32'(lc), 32'h000);
        rom[11'h002] = ret();
        release_reset();
        slot(); #1; chk("d_lc1b", 32'(lc), 32'h001);
        slot(); #1; chk("d_lc2b", 32'(lc), 32'h002);
        slot(); #1;
        chk("d_uflow_lc", 32'(lc), 32'h000);
        chk("d_err_before", 32'(err), 32'h0);
        slot(); #1;
        chk("d_uflow_err", 32'(err), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
